// File: rtl/sysid_check_ctrl.sv
// Boot-time / on-demand checker that reads sysid ID and timestamp over Avalon-MM and latches pass/fail.
// Optional mismatch interrupt enabled by defining SYSID_CHECK_IRQ_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1579707414,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        check_done,
  output logic        check_pass,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  wait_cnt_r;
  logic        m_read_r;
  logic        m_address_r;
  logic        auto_go_r;
  logic        done_r;
  logic        id_ok_r;
  logic        ts_ok_r;
  logic        timeout_r;
  logic        pass_r;
  logic [31:0] cap_id_r;
  logic [31:0] cap_ts_r;
  logic        busy_s;
  logic        start_s;
  logic        go_s;
  logic        abort_s;
  logic [31:0] rdata_s;

  assign busy_s  = (state_r != ST_IDLE);
  assign start_s = s_write && (s_address == 2'd0) && s_writedata[0] && !busy_s;
  assign go_s    = auto_go_r || start_s;

  // Next-state decode, including the stall-timeout abort path.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          next_state_s = ST_RD_ID;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        if (!m_waitrequest) begin
          next_state_s = (state_r == ST_RD_ID) ? ST_RD_TS : ST_DONE;
        end else if (wait_cnt_r == TIMEOUT) begin
          abort_s      = 1'b1;
          next_state_s = ST_DONE;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, registered master strobes and per-read stall counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      m_read_r    <= 1'b0;
      m_address_r <= 1'b0;
      wait_cnt_r  <= 8'd0;
    end else begin
      state_r     <= next_state_s;
      // Strobes follow the next state so they stay put for the whole stall.
      m_read_r    <= (next_state_s == ST_RD_ID) || (next_state_s == ST_RD_TS);
      m_address_r <= (next_state_s == ST_RD_TS);
      if ((next_state_s != state_r) || (state_r == ST_IDLE)) begin
        wait_cnt_r <= 8'd0;
      end else if (m_waitrequest) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Result flags and captured words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_go_r <= 1'b1;
      done_r    <= 1'b0;
      id_ok_r   <= 1'b0;
      ts_ok_r   <= 1'b0;
      timeout_r <= 1'b0;
      pass_r    <= 1'b0;
      cap_id_r  <= 32'd0;
      cap_ts_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          auto_go_r <= 1'b0;
          if (go_s) begin
            done_r    <= 1'b0;
            id_ok_r   <= 1'b0;
            ts_ok_r   <= 1'b0;
            timeout_r <= 1'b0;
            pass_r    <= 1'b0;
            cap_id_r  <= 32'd0;
            cap_ts_r  <= 32'd0;
          end
        end
        ST_RD_ID: begin
          if (!m_waitrequest) begin
            cap_id_r <= m_readdata;
            id_ok_r  <= (m_readdata == EXPECTED_ID);
          end else if (abort_s) begin
            timeout_r <= 1'b1;
          end
        end
        ST_RD_TS: begin
          if (!m_waitrequest) begin
            cap_ts_r <= m_readdata;
            ts_ok_r  <= (m_readdata == EXPECTED_TS);
          end else if (abort_s) begin
            timeout_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r <= 1'b1;
          pass_r <= id_ok_r && ts_ok_r && !timeout_r;
        end
        default: begin
          done_r <= done_r;
        end
      endcase
    end
  end

`ifdef SYSID_CHECK_IRQ_EN
  logic irq_en_r;
  logic irq_pend_r;
  logic fail_done_s;
  logic ctrl_wr_s;
  logic unused_s;

  assign fail_done_s = (state_r == ST_DONE) && !(id_ok_r && ts_ok_r && !timeout_r);
  assign ctrl_wr_s   = s_write && (s_address == 2'd3);
  assign unused_s    = ^{s_read, s_writedata[31:2]};

  // Interrupt enable and pending bit; a new failure beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r   <= 1'b0;
      irq_pend_r <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_r <= s_writedata[0];
      end
      if (fail_done_s) begin
        irq_pend_r <= 1'b1;
      end else if (ctrl_wr_s && s_writedata[1]) begin
        irq_pend_r <= 1'b0;
      end
    end
  end

  assign irq = irq_pend_r & irq_en_r;
`else
  logic unused_s;

  assign unused_s = ^{s_read, s_writedata[31:1]};
  assign irq      = 1'b0;
`endif

  // Zero-latency CSR read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (s_address)
      2'd0: rdata_s = {27'd0, busy_s, timeout_r, ts_ok_r, id_ok_r, done_r};
      2'd1: rdata_s = cap_id_r;
      2'd2: rdata_s = cap_ts_r;
`ifdef SYSID_CHECK_IRQ_EN
      2'd3: rdata_s = {30'd0, irq_pend_r, irq_en_r};
`else
      2'd3: rdata_s = 32'd0;
`endif
      default: rdata_s = 32'd0;
    endcase
  end

  assign s_readdata = rdata_s;
  assign m_read     = m_read_r;
  assign m_address  = m_address_r;
  assign check_done = done_r;
  assign check_pass = pass_r;

endmodule
